// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter from NUM_FU functional-unit result FIFOs onto
// NUM_WB_PORTS registered writeback ports, drained round-robin.
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   flush_in                 discard all buffered results and in-flight outputs
//   fu_valid_in/ready_out    per-FU push handshake (ready is a function of count only)
//   fu_dest/data/rob_ptr_in  per-FU result fields, FU i in slice i
//   wb_valid_out             per-port writeback valid
//   wb_dest/data/rob_ptr_out per-port writeback fields (0 when port unused)
//   wb_fu_id_out             source FU of each port
//   stall_cnt_out            present only with WB_ARB_STALL_CNT_EN defined: cycles
//                            where more FIFOs were non-empty than ports (saturating)
module wb_arbiter #(
  parameter int NUM_FU       = 4,
  parameter int NUM_WB_PORTS = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int WORD_SIZE    = 64,
  parameter int PREG_BITS    = 7,
  parameter int ROB_PTR_BITS = 6,
  localparam int FU_ID_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 flush_in,
  input  logic [NUM_FU-1:0]                    fu_valid_in,
  output logic [NUM_FU-1:0]                    fu_ready_out,
  input  logic [NUM_FU*PREG_BITS-1:0]          fu_dest_in,
  input  logic [NUM_FU*WORD_SIZE-1:0]          fu_data_in,
  input  logic [NUM_FU*ROB_PTR_BITS-1:0]       fu_rob_ptr_in,
  output logic [NUM_WB_PORTS-1:0]              wb_valid_out,
  output logic [NUM_WB_PORTS*PREG_BITS-1:0]    wb_dest_out,
  output logic [NUM_WB_PORTS*WORD_SIZE-1:0]    wb_data_out,
  output logic [NUM_WB_PORTS*ROB_PTR_BITS-1:0] wb_rob_ptr_out,
  output logic [NUM_WB_PORTS*FU_ID_W-1:0]      wb_fu_id_out
`ifdef WB_ARB_STALL_CNT_EN
  ,
  output logic [31:0]                          stall_cnt_out
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [FU_ID_W:0]   FU_LIM   = (FU_ID_W+1)'(NUM_FU);
  localparam logic [FU_ID_W-1:0] FU_LAST  = FU_ID_W'(NUM_FU - 1);

  typedef struct packed {
    logic [PREG_BITS-1:0]    dest;
    logic [WORD_SIZE-1:0]    data;
    logic [ROB_PTR_BITS-1:0] rob;
  } entry_t;

  entry_t             mem_q  [NUM_FU][FIFO_DEPTH];
  entry_t             mem_d  [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]   head_q [NUM_FU];
  logic [PTR_W-1:0]   head_d [NUM_FU];
  logic [PTR_W-1:0]   tail_q [NUM_FU];
  logic [PTR_W-1:0]   tail_d [NUM_FU];
  logic [CNT_W-1:0]   cnt_q  [NUM_FU];
  logic [CNT_W-1:0]   cnt_d  [NUM_FU];
  logic [FU_ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_WB_PORTS-1:0]              wb_valid_q, wb_valid_d;
  logic [NUM_WB_PORTS*PREG_BITS-1:0]    wb_dest_q, wb_dest_d;
  logic [NUM_WB_PORTS*WORD_SIZE-1:0]    wb_data_q, wb_data_d;
  logic [NUM_WB_PORTS*ROB_PTR_BITS-1:0] wb_rob_q, wb_rob_d;
  logic [NUM_WB_PORTS*FU_ID_W-1:0]      wb_fu_id_q, wb_fu_id_d;

  logic [NUM_FU-1:0]       grant;
  logic [NUM_WB_PORTS-1:0] port_vld;
  logic [FU_ID_W-1:0]      port_sel [NUM_WB_PORTS];
  logic [FU_ID_W-1:0]      last_win;
  logic [FU_ID_W:0]        scan_sum;
  logic [FU_ID_W-1:0]      scan_idx;
  int unsigned             n_win;

  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_ready_out[i] = !rst_in && (cnt_q[i] != CNT_FULL);
    end
  end

  // Rotating scan from rr_ptr; the k-th non-empty FIFO found lands on port k.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    n_win    = 0;
    last_win = rr_ptr_q;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
      port_sel[p] = '0;
    end
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (FU_ID_W+1)'(k);
      if (scan_sum >= FU_LIM) begin
        scan_sum = scan_sum - FU_LIM;
      end
      scan_idx = scan_sum[FU_ID_W-1:0];
      if (cnt_q[scan_idx] != '0 && n_win < NUM_WB_PORTS) begin
        for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
          if (p == n_win) begin
            port_sel[p] = scan_idx;
            port_vld[p] = 1'b1;
          end
        end
        grant[scan_idx] = 1'b1;
        last_win        = scan_idx;
        n_win           = n_win + 1;
      end
    end
  end

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = '0;
    wb_dest_d  = '0;
    wb_data_d  = '0;
    wb_rob_d   = '0;
    wb_fu_id_d = '0;
    if (flush_in) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        head_d[i] = '0;
        tail_d[i] = '0;
        cnt_d[i]  = '0;
      end
      rr_ptr_d = '0;
    end else begin
      for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
        if (port_vld[p]) begin
          wb_valid_d[p]                                 = 1'b1;
          wb_dest_d[p*PREG_BITS +: PREG_BITS]           = mem_q[port_sel[p]][head_q[port_sel[p]]].dest;
          wb_data_d[p*WORD_SIZE +: WORD_SIZE]           = mem_q[port_sel[p]][head_q[port_sel[p]]].data;
          wb_rob_d[p*ROB_PTR_BITS +: ROB_PTR_BITS]      = mem_q[port_sel[p]][head_q[port_sel[p]]].rob;
          wb_fu_id_d[p*FU_ID_W +: FU_ID_W]              = port_sel[p];
        end
      end
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (fu_valid_in[i] && fu_ready_out[i]) begin
          mem_d[i][tail_q[i]].dest = fu_dest_in[i*PREG_BITS +: PREG_BITS];
          mem_d[i][tail_q[i]].data = fu_data_in[i*WORD_SIZE +: WORD_SIZE];
          mem_d[i][tail_q[i]].rob  = fu_rob_ptr_in[i*ROB_PTR_BITS +: ROB_PTR_BITS];
          tail_d[i] = tail_q[i] + 1'b1;
        end
        if (grant[i]) begin
          head_d[i] = head_q[i] + 1'b1;
        end
        case ({fu_valid_in[i] && fu_ready_out[i], grant[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
          2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
      if (n_win != 0) begin
        rr_ptr_d = (last_win == FU_LAST) ? '0 : last_win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_ptr_q   <= '0;
      wb_valid_q <= '0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      wb_rob_q   <= '0;
      wb_fu_id_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      wb_rob_q   <= wb_rob_d;
      wb_fu_id_q <= wb_fu_id_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign wb_valid_out   = wb_valid_q;
  assign wb_dest_out    = wb_dest_q;
  assign wb_data_out    = wb_data_q;
  assign wb_rob_ptr_out = wb_rob_q;
  assign wb_fu_id_out   = wb_fu_id_q;

`ifdef WB_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  int unsigned n_busy;

  always_comb begin
    n_busy      = 0;
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (cnt_q[i] != '0) begin
        n_busy = n_busy + 1;
      end
    end
    if (flush_in) begin
      stall_cnt_d = '0;
    end else if (n_busy > NUM_WB_PORTS && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`else
  // Stall accounting compiled out.
`endif

endmodule
